decode_pipe_unit: RTL and testbench

DECODE_PIPE_UNIT -- requirements
Module: decode_pipe_unit

---
 rtl/decode_pipe_unit.sv | 166 ++++++++++++++++
 tb/tb_decode_pipe_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_unit.sv
// Instruction decode stage: register file with write-through reads, main control
// decode, load-use hazard detection and the ID/EX pipeline register.
module decode_pipe_unit #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_valid,
   input  logic [31:0]        if_instr,
   output logic               id_ready,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               ex_flush,
   input  logic               ex_ready,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  ex_rd1,
   output logic [DATA_W-1:0]  ex_rd2,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [RADDR_W-1:0] ex_rs,
   output logic [RADDR_W-1:0] ex_rt,
   output logic [RADDR_W-1:0] ex_rd,
   output logic [1:0]         ex_aluop,
   output logic               ex_regdst,
   output logic               ex_alusrc,
   output logic               ex_memtoreg,
   output logic               ex_branch,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite
);

   localparam int DEPTH = 2 ** RADDR_W;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011,
      OP_BEQ   = 6'b000100
   } opcode_e;

   logic [DATA_W-1:0]  regs [DEPTH];
   logic [RADDR_W-1:0] rs, rt, rd;
   logic [15:0]        imm;
   logic [DATA_W-1:0]  imm_ext;
   logic [DATA_W-1:0]  rd1, rd2;
   logic               wb_active;
   logic               hazard, advance;

   logic [1:0] dec_aluop;
   logic       dec_regdst, dec_alusrc, dec_memtoreg, dec_branch;
   logic       dec_regwrite, dec_memread, dec_memwrite;

   assign rs      = RADDR_W'(if_instr[25:21]);
   assign rt      = RADDR_W'(if_instr[20:16]);
   assign rd      = RADDR_W'(if_instr[15:11]);
   assign imm     = if_instr[15:0];
   assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};

   assign wb_active = wb_we && (wb_addr != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         regs <= '{default: '0};
      end else if (wb_active) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Write-through bypass first, then the r0 override so r0 can never be forwarded.
   always_comb begin
      rd1 = regs[rs];
      rd2 = regs[rt];
      if (wb_active && (wb_addr == rs)) rd1 = wb_data;
      if (wb_active && (wb_addr == rt)) rd2 = wb_data;
      if (rs == '0) rd1 = '0;
      if (rt == '0) rd2 = '0;
   end

   always_comb begin
      dec_aluop    = 2'b00;
      dec_regdst   = 1'b0;
      dec_alusrc   = 1'b0;
      dec_memtoreg = 1'b0;
      dec_branch   = 1'b0;
      dec_regwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_memwrite = 1'b0;
      case (if_instr[31:26])
         OP_RTYPE: begin
            dec_regdst   = 1'b1;
            dec_regwrite = 1'b1;
            dec_aluop    = 2'b10;
         end
         OP_LW: begin
            dec_alusrc   = 1'b1;
            dec_memtoreg = 1'b1;
            dec_regwrite = 1'b1;
            dec_memread  = 1'b1;
         end
         OP_SW: begin
            dec_alusrc   = 1'b1;
            dec_memwrite = 1'b1;
         end
         OP_BEQ: begin
            dec_branch = 1'b1;
            dec_aluop  = 2'b01;
         end
         default: ;
      endcase
   end

   assign hazard   = ex_valid && ex_memread && (ex_rt != '0) && if_valid &&
                     ((ex_rt == rs) || (ex_rt == rt));
   assign advance  = !ex_valid || ex_ready;
   assign id_ready = !reset && (ex_flush || (advance && !hazard));

   // Controls are cleared whenever ex_valid drops so an empty slot never carries live controls.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_aluop    <= '0;
         ex_regdst   <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_branch   <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
      end else if (ex_flush || (advance && hazard)) begin
         ex_valid    <= 1'b0;
         ex_aluop    <= '0;
         ex_regdst   <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_branch   <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
      end else if (advance) begin
         ex_valid    <= if_valid;
         ex_rd1      <= rd1;
         ex_rd2      <= rd2;
         ex_imm      <= imm_ext;
         ex_rs       <= rs;
         ex_rt       <= rt;
         ex_rd       <= rd;
         ex_aluop    <= if_valid ? dec_aluop : 2'b00;
         ex_regdst   <= if_valid && dec_regdst;
         ex_alusrc   <= if_valid && dec_alusrc;
         ex_memtoreg <= if_valid && dec_memtoreg;
         ex_branch   <= if_valid && dec_branch;
         ex_regwrite <= if_valid && dec_regwrite;
         ex_memread  <= if_valid && dec_memread;
         ex_memwrite <= if_valid && dec_memwrite;
      end
   end

endmodule

// File: tb/tb_decode_pipe_unit.sv
// Scoreboard bench for decode_pipe_unit: directed instructions push expected ID/EX
// contents; a negedge monitor pops and compares on every transfer to execute.
module tb_decode_pipe_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        id_ready;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_flush;
   logic        ex_ready;
   logic        ex_valid;
   logic [31:0] ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [1:0]  ex_aluop;
   logic        ex_regdst, ex_alusrc, ex_memtoreg, ex_branch;
   logic        ex_regwrite, ex_memread, ex_memwrite;

   decode_pipe_unit #(.DATA_W(32), .RADDR_W(5)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
      .id_ready(id_ready), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_flush(ex_flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_aluop(ex_aluop),
      .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
      .ex_branch(ex_branch), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [1:0]  aluop;
      logic [6:0]  ctrl;   // {regdst, alusrc, memtoreg, branch, regwrite, memread, memwrite}
   } exp_t;

   localparam logic [6:0] C_R   = 7'b1000100;
   localparam logic [6:0] C_LW  = 7'b0110110;
   localparam logic [6:0] C_SW  = 7'b0100001;
   localparam logic [6:0] C_BEQ = 7'b0001000;
   localparam logic [6:0] C_NO  = 7'b0000000;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic mon_en   = 1'b0;
   logic [6:0] act_ctrl;

   assign act_ctrl = {ex_regdst, ex_alusrc, ex_memtoreg, ex_branch,
                      ex_regwrite, ex_memread, ex_memwrite};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic exp_t ex(input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [1:0] aluop, input logic [6:0] ctrl);
      exp_t e;
      e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.rs = rs; e.rt = rt; e.rd = rd;
      e.aluop = aluop; e.ctrl = ctrl;
      return e;
   endfunction

   // Monitor: a transfer to execute is ex_valid & ex_ready at the coming edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ex_valid && ex_ready) begin
            exp_t act, req;
            act = {ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_aluop, act_ctrl};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_issue: got %h expected none", act);
            end else begin
               req = exp_q.pop_front();
               if (act !== req) begin
                  failures++;
                  $display("FAIL issue: got %h expected %h", act, req);
               end
            end
         end
         if (!ex_valid) check("idle_ctrl", {55'd0, ex_aluop, act_ctrl}, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_valid = 1'b0; ex_flush = 1'b0; wb_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1; if_valid = 1'b0; if_instr = '0; wb_we = 1'b0; wb_addr = '0;
      wb_data = '0; ex_flush = 1'b0; ex_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // reset dominates flush, writeback and a presented instruction
      if_valid = 1'b1; if_instr = mk(6'b000000, 5'd1, 5'd2, 16'h1820);
      ex_flush = 1'b1; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hFF;
      #1 check("id_ready_in_reset", {63'd0, id_ready}, 64'd0);
      step();
      reset = 1'b0; idle_inputs();
      check("reset_valid", {63'd0, ex_valid}, 64'd0);
      check("reset_ctrl", {55'd0, ex_aluop, act_ctrl}, 64'd0);
      mon_en = 1'b1;

      // r3 = 0xAA, then R-type rs=3 rt=0 rd=4
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_00AA;
      step();
      wb_we = 1'b0;
      if_valid = 1'b1; if_instr = mk(6'b000000, 5'd3, 5'd0, 16'h2020);
      exp_q.push_back(ex(32'hAA, 32'h0, 32'h2020, 5'd3, 5'd0, 5'd4, 2'b10, C_R));
      step();

      // write-through: r5 written in the same cycle BEQ reads it
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
      if_instr = mk(6'b000100, 5'd5, 5'd3, 16'h0010);
      exp_q.push_back(ex(32'h1234, 32'hAA, 32'h10, 5'd5, 5'd3, 5'd0, 2'b01, C_BEQ));
      step();

      // write to r0 must neither bypass nor stick
      wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
      if_instr = mk(6'b101011, 5'd0, 5'd5, 16'hFFFC);
      exp_q.push_back(ex(32'h0, 32'h1234, 32'hFFFF_FFFC, 5'd0, 5'd5, 5'd31, 2'b00, C_SW));
      step();
      wb_we = 1'b0;

      // load-use: LW rt=7 followed by a reader of r7
      if_instr = mk(6'b100011, 5'd3, 5'd7, 16'h0004);
      exp_q.push_back(ex(32'hAA, 32'h0, 32'h4, 5'd3, 5'd7, 5'd0, 2'b00, C_LW));
      step();
      if_instr = mk(6'b000000, 5'd7, 5'd0, 16'h0820);
      wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
      #1 check("hazard_stall", {63'd0, id_ready}, 64'd0);
      step();
      wb_we = 1'b0;
      check("bubble_valid", {63'd0, ex_valid}, 64'd0);
      #1 check("after_bubble_ready", {63'd0, id_ready}, 64'd1);
      exp_q.push_back(ex(32'h77, 32'h0, 32'h0820, 5'd7, 5'd0, 5'd1, 2'b10, C_R));
      step();
      if_valid = 1'b0;
      step();

      // flush consumes and discards the presented instruction
      if_valid = 1'b1; if_instr = mk(6'b100011, 5'd1, 5'd1, 16'h0001); ex_flush = 1'b1;
      #1 check("flush_ready", {63'd0, id_ready}, 64'd1);
      step();
      idle_inputs();
      check("flush_valid", {63'd0, ex_valid}, 64'd0);
      step();
      check("flush_not_reissued", {63'd0, ex_valid}, 64'd0);

      // stall: LW with negative imm held for three cycles of ex_ready=0
      if_valid = 1'b1; if_instr = mk(6'b100011, 5'd0, 5'd2, 16'h8000);
      exp_q.push_back(ex(32'h0, 32'h0, 32'hFFFF_8000, 5'd0, 5'd2, 5'd16, 2'b00, C_LW));
      step();
      ex_ready = 1'b0;
      if_instr = mk(6'b001000, 5'd4, 5'd5, 16'h7FFF);
      #1 check("stall_ready", {63'd0, id_ready}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #2;
         check("stall_valid", {63'd0, ex_valid}, 64'd1);
         check("stall_imm", {32'd0, ex_imm}, {32'd0, 32'hFFFF_8000});
         check("stall_fields", {44'd0, ex_rs, ex_rt, ex_rd, act_ctrl}, {44'd0, 5'd0, 5'd2, 5'd16, C_LW});
         check("stall_id_ready", {63'd0, id_ready}, 64'd0);
      end
      #1 ex_ready = 1'b1;
      #1 check("stall_release", {63'd0, id_ready}, 64'd1);
      exp_q.push_back(ex(32'h0, 32'h1234, 32'h7FFF, 5'd4, 5'd5, 5'd15, 2'b00, C_NO));
      step();
      if_valid = 1'b0;
      step();

      // reset mid-stream
      if_valid = 1'b1; if_instr = mk(6'b000000, 5'd3, 5'd5, 16'h1000);
      exp_q.push_back(ex(32'hAA, 32'h1234, 32'h1000, 5'd3, 5'd5, 5'd2, 2'b10, C_R));
      step();
      reset = 1'b1; ex_flush = 1'b1; wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
      if_instr = mk(6'b100011, 5'd1, 5'd1, 16'h0002);
      #1 check("reset_mid_ready", {63'd0, id_ready}, 64'd0);
      step();
      reset = 1'b0; idle_inputs();
      check("reset_mid_valid", {63'd0, ex_valid}, 64'd0);
      check("reset_mid_ctrl", {55'd0, ex_aluop, act_ctrl}, 64'd0);
      check("reset_mid_data", {32'd0, ex_rd1}, 64'd0);

      // every register reads zero after reset
      for (int unsigned i = 1; i < 32; i++) begin
         logic [4:0]  a, b;
         logic [15:0] im;
         a  = i[4:0];
         b  = 5'(32 - i);
         im = {a, 11'd0};
         if_valid = 1'b1; if_instr = mk(6'b000000, a, b, im);
         exp_q.push_back(ex(32'h0, 32'h0, {{16{im[15]}}, im}, a, b, a, 2'b10, C_R));
         step();
      end
      if_valid = 1'b0;
      for (int n = 0; n < 10 && exp_q.size() != 0; n++) step();
      step();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
